// File: rtl/frame_buf_pkg.sv
// -----------------------------------------------------------------------------
// frame_buf_pkg
// Shared definitions for the frame buffer config/status bank:
//   - Avalon word addresses of the register map
//   - CTRL / IRQ bit positions and the STATUS pointer field offset
//   - sequencer state encoding (visible to software through STATUS[1:0])
// -----------------------------------------------------------------------------
package frame_buf_pkg;

    // Register map (word addresses)
    localparam int ADDR_CTRL      = 0;
    localparam int ADDR_IMG_SIZE  = 1;
    localparam int ADDR_BUF_FULL  = 2;
    localparam int ADDR_IRQ_STAT  = 3;
    localparam int ADDR_IRQ_MASK  = 4;
    localparam int ADDR_FRAME_CNT = 5;
    localparam int ADDR_STATUS    = 6;
    localparam int BASE_OFFSET    = 16;

    // CTRL bits
    localparam int CTRL_ENABLE_BIT     = 0;
    localparam int CTRL_SOFT_CLEAR_BIT = 1;

    // IRQ_STAT / IRQ_MASK bits
    localparam int IRQ_FRAME_DONE_BIT = 0;
    localparam int IRQ_UNDERRUN_BIT   = 1;
    localparam int IRQ_W              = 2;

    // STATUS: ptr field starts here
    localparam int STATUS_PTR_LSB = 8;

    // Sequencer states; encoding is software-visible
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_ACTIVE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/frame_buf_sequencer.sv
// -----------------------------------------------------------------------------
// frame_buf_sequencer
// Hands full buffers to the reader in strict ring order and releases each one
// when the reader signals the end of the frame.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   enable          CTRL.enable
//   soft_clear      one-cycle CTRL.soft_clear write strobe
//   img_end         reader pulse: current frame consumed
//   full            per-buffer full flags (owned by the register bank)
//   base            per-buffer base addresses
//   state, ptr      current FSM state and ring pointer (for STATUS)
//   frame_start     one-cycle pulse on the first cycle of a grant
//   frame_active    reader owns cur_idx
//   cur_idx/base    granted buffer, latched at grant time
//   frame_done      combinational event: release full[cur_idx], count frame
//   underrun        combinational event: SEARCH entered with full[ptr]=0
// -----------------------------------------------------------------------------
module frame_buf_sequencer
    import frame_buf_pkg::*;
#(
    parameter int NUM_BUF = 2,
    parameter int DATA_W  = 32,
    parameter int IDX_W   = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic                             soft_clear,
    input  logic                             img_end,
    input  logic [NUM_BUF-1:0]               full,
    input  logic [NUM_BUF-1:0][DATA_W-1:0]   base,
    output seq_state_t                       state,
    output logic [IDX_W-1:0]                 ptr,
    output logic                             frame_start,
    output logic                             frame_active,
    output logic [IDX_W-1:0]                 cur_idx,
    output logic [DATA_W-1:0]                cur_base,
    output logic                             frame_done,
    output logic                             underrun
);

    seq_state_t       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             entry_q;   // first cycle after entering SEARCH
    logic             grant;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant      = 1'b0;
        frame_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_SEARCH;
            end
            ST_SEARCH: begin
                // No skipping: only the buffer at ptr may be granted.
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (full[ptr_q]) begin
                    grant   = 1'b1;
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                // Dropping enable only takes effect once the frame completes.
                if (img_end) begin
                    frame_done = 1'b1;
                    ptr_d      = (ptr_q == IDX_W'(NUM_BUF - 1)) ? '0 : ptr_q + IDX_W'(1);
                    state_d    = enable ? ST_SEARCH : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Underrun is flagged once per entry into SEARCH, not every cycle spent waiting.
        underrun = (state_q == ST_SEARCH) && entry_q && !full[ptr_q];

        // soft_clear overrides every transition and suppresses all events.
        if (soft_clear) begin
            state_d    = ST_IDLE;
            ptr_d      = '0;
            grant      = 1'b0;
            frame_done = 1'b0;
            underrun   = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            entry_q     <= 1'b0;
            frame_start <= 1'b0;
            cur_idx     <= '0;
            cur_base    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            entry_q     <= (state_d == ST_SEARCH) && (state_q != ST_SEARCH);
            frame_start <= grant;
            // cur_base is a snapshot: later BASE rewrites wait for the next grant.
            if (grant) begin
                cur_idx  <= ptr_q;
                cur_base <= base[ptr_q];
            end
        end
    end

    assign state        = state_q;
    assign ptr          = ptr_q;
    assign frame_active = (state_q == ST_ACTIVE);

endmodule

// File: rtl/frame_buf_cfg_bank.sv
// -----------------------------------------------------------------------------
// frame_buf_cfg_bank
// Avalon-MM config/status bank for an NUM_BUF-deep frame store. Software
// programs base addresses and image size and marks buffers full; the
// sequencer hands them to the reader and releases them on frame end.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   avalon_write/read    transfer strobes
//   avalon_addr          word address
//   avalon_byteenable    write byte lanes
//   avalon_write_data    write data
//   avalon_read_data     registered read data (1-cycle latency, 0 when idle)
//   img_end              reader pulse: current frame consumed
//   frame_start          one-cycle pulse: new buffer granted
//   frame_active         reader owns cur_idx
//   cur_idx, cur_base    granted buffer index / base address
//   img_size             IMG_SIZE register
//   irq                  |(IRQ_STAT & IRQ_MASK)
// -----------------------------------------------------------------------------
module frame_buf_cfg_bank
    import frame_buf_pkg::*;
#(
    parameter int NUM_BUF = 2,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int IDX_W   = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                avalon_write,
    input  logic                avalon_read,
    input  logic [ADDR_W-1:0]   avalon_addr,
    input  logic [DATA_W/8-1:0] avalon_byteenable,
    input  logic [DATA_W-1:0]   avalon_write_data,
    output logic [DATA_W-1:0]   avalon_read_data,
    input  logic                img_end,
    output logic                frame_start,
    output logic                frame_active,
    output logic [IDX_W-1:0]    cur_idx,
    output logic [DATA_W-1:0]   cur_base,
    output logic [DATA_W-1:0]   img_size,
    output logic                irq
);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic                           ctrl_en_q;
    logic [DATA_W-1:0]              img_size_q;
    logic [NUM_BUF-1:0]             full_q, full_d;
    logic [IRQ_W-1:0]               irq_stat_q, irq_stat_d;
    logic [IRQ_W-1:0]               irq_mask_q;
    logic [DATA_W-1:0]              frame_cnt_q;
    logic [NUM_BUF-1:0][DATA_W-1:0] base_q;

    // ------------------------------------------------------------------
    // Write decode and byte-lane merge
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]  be_mask;
    logic [DATA_W-1:0]  wdata_m;
    logic               wr_ctrl, wr_img_size, wr_full, wr_irq_stat, wr_irq_mask;
    logic [NUM_BUF-1:0] wr_base;
    logic               soft_clear;
    logic [NUM_BUF-1:0] full_w1s;
    logic [IRQ_W-1:0]   irq_w1c;

    always_comb begin
        be_mask = '0;
        for (int b = 0; b < DATA_W / 8; b++) begin
            be_mask[b*8 +: 8] = {8{avalon_byteenable[b]}};
        end
    end

    assign wdata_m = avalon_write_data & be_mask;

    assign wr_ctrl     = avalon_write && (avalon_addr == ADDR_W'(ADDR_CTRL));
    assign wr_img_size = avalon_write && (avalon_addr == ADDR_W'(ADDR_IMG_SIZE));
    assign wr_full     = avalon_write && (avalon_addr == ADDR_W'(ADDR_BUF_FULL));
    assign wr_irq_stat = avalon_write && (avalon_addr == ADDR_W'(ADDR_IRQ_STAT));
    assign wr_irq_mask = avalon_write && (avalon_addr == ADDR_W'(ADDR_IRQ_MASK));

    always_comb begin
        wr_base = '0;
        for (int i = 0; i < NUM_BUF; i++) begin
            wr_base[i] = avalon_write && (avalon_addr == ADDR_W'(BASE_OFFSET + i));
        end
    end

    assign soft_clear = wr_ctrl && wdata_m[CTRL_SOFT_CLEAR_BIT];
    assign full_w1s   = wr_full     ? wdata_m[NUM_BUF-1:0] : '0;
    assign irq_w1c    = wr_irq_stat ? wdata_m[IRQ_W-1:0]   : '0;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    seq_state_t       seq_state;
    logic [IDX_W-1:0] seq_ptr;
    logic             frame_done;
    logic             underrun;

    frame_buf_sequencer #(
        .NUM_BUF (NUM_BUF),
        .DATA_W  (DATA_W),
        .IDX_W   (IDX_W)
    ) u_seq (
        .clk          (clk),
        .rst          (rst),
        .enable       (ctrl_en_q),
        .soft_clear   (soft_clear),
        .img_end      (img_end),
        .full         (full_q),
        .base         (base_q),
        .state        (seq_state),
        .ptr          (seq_ptr),
        .frame_start  (frame_start),
        .frame_active (frame_active),
        .cur_idx      (cur_idx),
        .cur_base     (cur_base),
        .frame_done   (frame_done),
        .underrun     (underrun)
    );

    // ------------------------------------------------------------------
    // Flag next-state: hardware set/clear combined with software W1S/W1C
    // ------------------------------------------------------------------
    always_comb begin
        // Release first, then W1S, so a same-cycle software set wins.
        full_d = full_q;
        if (frame_done) full_d[cur_idx] = 1'b0;
        full_d = full_d | full_w1s;
        if (soft_clear) full_d = '0;

        // W1C first, then hardware set, so a same-cycle event wins.
        irq_stat_d = irq_stat_q & ~irq_w1c;
        irq_stat_d[IRQ_FRAME_DONE_BIT] = irq_stat_d[IRQ_FRAME_DONE_BIT] | frame_done;
        irq_stat_d[IRQ_UNDERRUN_BIT]   = irq_stat_d[IRQ_UNDERRUN_BIT]   | underrun;
    end

    // ------------------------------------------------------------------
    // Read mux (pre-update register values)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        if (avalon_addr == ADDR_W'(ADDR_CTRL)) begin
            rd_mux[CTRL_ENABLE_BIT] = ctrl_en_q;
        end else if (avalon_addr == ADDR_W'(ADDR_IMG_SIZE)) begin
            rd_mux = img_size_q;
        end else if (avalon_addr == ADDR_W'(ADDR_BUF_FULL)) begin
            rd_mux[NUM_BUF-1:0] = full_q;
        end else if (avalon_addr == ADDR_W'(ADDR_IRQ_STAT)) begin
            rd_mux[IRQ_W-1:0] = irq_stat_q;
        end else if (avalon_addr == ADDR_W'(ADDR_IRQ_MASK)) begin
            rd_mux[IRQ_W-1:0] = irq_mask_q;
        end else if (avalon_addr == ADDR_W'(ADDR_FRAME_CNT)) begin
            rd_mux = frame_cnt_q;
        end else if (avalon_addr == ADDR_W'(ADDR_STATUS)) begin
            rd_mux[1:0]                        = seq_state;
            rd_mux[STATUS_PTR_LSB +: IDX_W]    = seq_ptr;
        end
        for (int i = 0; i < NUM_BUF; i++) begin
            if (avalon_addr == ADDR_W'(BASE_OFFSET + i)) rd_mux = base_q[i];
        end
    end

    // ------------------------------------------------------------------
    // Register updates
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_en_q        <= 1'b0;
            img_size_q       <= '0;
            full_q           <= '0;
            irq_stat_q       <= '0;
            irq_mask_q       <= '0;
            frame_cnt_q      <= '0;
            // NOTE: the BASE array is a small flop bank, not a RAM, so it is
            // reset like every other register and reads 0 after reset.
            base_q           <= '0;
            avalon_read_data <= '0;
        end else begin
            if (wr_ctrl && avalon_byteenable[0]) begin
                ctrl_en_q <= avalon_write_data[CTRL_ENABLE_BIT];
            end
            if (wr_img_size) begin
                img_size_q <= (img_size_q & ~be_mask) | wdata_m;
            end
            if (wr_irq_mask && avalon_byteenable[0]) begin
                irq_mask_q <= avalon_write_data[IRQ_W-1:0];
            end
            for (int i = 0; i < NUM_BUF; i++) begin
                if (wr_base[i]) base_q[i] <= (base_q[i] & ~be_mask) | wdata_m;
            end

            full_q     <= full_d;
            irq_stat_q <= irq_stat_d;

            if (soft_clear) begin
                frame_cnt_q <= '0;
            end else if (frame_done) begin
                frame_cnt_q <= frame_cnt_q + DATA_W'(1);
            end

            avalon_read_data <= avalon_read ? rd_mux : '0;
        end
    end

    assign img_size = img_size_q;
    assign irq      = |(irq_stat_q & irq_mask_q);

endmodule

// File: doc/frame_buf_cfg_bank.md
Name: frame_buf_cfg_bank

Overview:
Parametrised Avalon-MM config/status block for an N-buffer frame store between HPS (producer) and the PL display/inspection reader (consumer). The HPS programs per-buffer base addresses and image size, and marks buffers full. An internal sequencer hands full buffers to the reader in strict ring order and releases each one on frame end. It also raises maskable interrupts and counts frames. It generalises the two-buffer ping-pong config bus to NUM_BUF buffers, with byte enables, W1S/W1C semantics and an explicit sequencer FSM.

Parameters:
NUM_BUF, 2, number of frame buffers (2..16)
DATA_W, 32, Avalon data width (multiple of 8)
ADDR_W, 5, Avalon word address width
IDX_W, $clog2(NUM_BUF), buffer index width (derived, min 1)

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  asynchronous reset, active-high
avalon_write  in  1  write strobe
avalon_read  in  1  read strobe
avalon_addr  in  ADDR_W  word address
avalon_byteenable  in  DATA_W/8  write byte lanes
avalon_write_data  in  DATA_W  write data
avalon_read_data  out  DATA_W  registered read data
img_end  in  1  reader pulse: current frame fully consumed
frame_start  out  1  one-cycle pulse: new buffer granted
frame_active  out  1  reader owns cur_idx
cur_idx  out  IDX_W  granted buffer index
cur_base  out  DATA_W  granted buffer base address
img_size  out  DATA_W  image size register
irq  out  1  level interrupt, |(IRQ_STAT & IRQ_MASK)

Behaviour:
- Reset: all registers 0, FSM IDLE, ptr=0. Outputs avalon_read_data, frame_start, frame_active, cur_idx, cur_base, img_size and irq are all 0.
- Register map (word addr):
  - 0 CTRL: bit0 enable (RW); bit1 soft_clear (W1, self-clearing, reads 0)
  - 1 IMG_SIZE (RW)
  - 2 BUF_FULL: write-1-to-set bits[NUM_BUF-1:0]; read returns full flags
  - 3 IRQ_STAT (W1C): bit0 frame_done, bit1 underrun
  - 4 IRQ_MASK (RW)
  - 5 FRAME_CNT (RO, wraps)
  - 6 STATUS (RO): [1:0] FSM state, [8+IDX_W-1:8] ptr
  - 16+i BASE[i] (RW)
- Writes honour byteenable per lane. Writes to RO/unmapped addresses are ignored.
- Reads: 1-cycle latency. Data is the value before any same-cycle update. Unmapped address returns 0. avalon_read_data is 0 in cycles with no read.
- FSM IDLE -> SEARCH when enable=1.
- FSM SEARCH:
  - if full[ptr]: go to ACTIVE; latch cur_idx=ptr and cur_base=BASE[ptr]; pulse frame_start in the same cycle as the transition.
  - else stay, with no skipping. Underrun sets on the cycle of entering SEARCH with full[ptr]=0 (set once per entry).
  - enable=0 -> IDLE.
- FSM ACTIVE (frame_active=1):
  - on img_end: clear full[cur_idx], set frame_done, FRAME_CNT+1, ptr=(ptr==NUM_BUF-1)?0:ptr+1.
  - then SEARCH if enable=1, else IDLE. Dropping enable mid-frame completes the frame first.
- img_end outside ACTIVE is ignored.
- Simultaneous events:
  - HW release and SW W1S of the same bit: bit ends 1.
  - HW IRQ set and W1C of the same bit: bit ends 1.
  - soft_clear beats everything: full flags=0, ptr=0, FSM->IDLE, IRQ_STAT unchanged, FRAME_CNT=0.
- BASE[cur_idx] rewritten during ACTIVE does not change cur_base until the next grant.
- rst asserted mid-frame: immediate return to reset values.

Decomposition:
- Package frame_buf_pkg:
  - register address constants and CTRL/IRQ bit positions
  - FSM state enum (IDLE=0, SEARCH=1, ACTIVE=2)
  - BASE_OFFSET=16
- Sub-module frame_buf_sequencer: FSM, ptr, full-flag release, frame_start/irq event generation.
- Top: Avalon register decode, byte-enable merge, read mux.

Test Plan:
1. Reset then read all addrs -> all 0. Write BASE[1]=0x3000_0000 with byteenable=4'b0011 -> reads 0x0000_0000.
2. NUM_BUF=3: BASE[0..2]=0x100/0x200/0x300, BUF_FULL=3'b111, CTRL=1 -> three grants in order 0,1,2, each on an img_end. cur_base follows 0x100/0x200/0x300. FRAME_CNT=3; full=0.
3. Enable with BUF_FULL=0 -> state SEARCH, IRQ_STAT=2'b10. With IRQ_MASK=2, irq=1. Write IRQ_STAT=2 -> irq=0. Then write BUF_FULL=1 -> frame_start next cycle, cur_idx=0.
4. During ACTIVE on buffer 1, same cycle: img_end plus W1S BUF_FULL=2 and W1C IRQ_STAT=1 -> full[1]=1, frame_done=1, ptr advances to 0 (NUM_BUF=2 wrap).
5. ACTIVE, write CTRL=0 -> stays ACTIVE until img_end, then IDLE. Repeat with soft_clear instead -> IDLE next cycle, full=0, FRAME_CNT=0.
6. Assert rst mid-ACTIVE -> frame_active, cur_base, avalon_read_data and irq are 0 immediately (asynchronous).
